// File: rtl/adc_cfg_pkg.sv
// Shared types and constants for the ADC configuration sequencer:
// frame width, FSM state encoding and the default register table.
package adc_cfg_pkg;

  localparam int ADC_FRAME_W  = 40;
  localparam int DEF_NUM_REGS = 8;

  typedef logic [ADC_FRAME_W-1:0] frame_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_REQ,
    ST_XFER,
    ST_SETTLE,
    ST_READY
  } state_e;

  // Default ADC register image, sent in index order after the init frame.
  localparam frame_t DEF_REG_TABLE [DEF_NUM_REGS] = '{
    40'h00_0000_0001,
    40'h00_0100_0203,
    40'h00_0200_0480,
    40'h00_0300_0010,
    40'h00_0400_00F0,
    40'h00_0500_1234,
    40'h00_0600_0008,
    40'h00_0700_00C3
  };

  // Table lookup; entries past the default image get a recognisable filler
  // word carrying the index so larger NUM_REGS builds stay deterministic.
  function automatic frame_t cfg_rom_word(input logic [5:0] idx);
    frame_t w;
    if (idx < 6'(DEF_NUM_REGS)) w = DEF_REG_TABLE[idx[2:0]];
    else                        w = {8'h80, 2'b00, idx, 24'h00_0000};
    return w;
  endfunction

endpackage

// File: rtl/adc_cfg_rom.sv
// Register table read port: one registered clock of latency, read on demand.
module adc_cfg_rom
  import adc_cfg_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] idx_i,
  output frame_t           data_o
);

  logic [5:0] addr;
  frame_t     data_q;

  assign addr   = 6'(idx_i);
  assign data_o = data_q;

  // Capture the addressed table word when a read is issued.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)     data_q <= '0;
    else if (rd_en_i) data_q <= cfg_rom_word(addr);
  end

endmodule

// File: rtl/adc_cfg_sequencer.sv
// ADC configuration sequencer: sends a CRC-disable init frame followed by
// the register table through the SPI master's start/busy handshake, with a
// settle gap after each frame. Optional runtime single-register writes are
// enabled by defining ADC_CFG_RUNTIME_WR_EN.
module adc_cfg_sequencer
  import adc_cfg_pkg::*;
#(
  parameter int NUM_REGS      = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int START_TIMEOUT = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   cfg_go_i,
  output logic                   cfg_done_o,
  output logic                   cfg_err_o,
  output logic                   seq_busy_o,
  output logic                   spi_start_o,
  output logic                   spi_init_o,
  input  logic                   spi_busy_i,
  output logic [ADC_FRAME_W-1:0] spi_data_o
`ifdef ADC_CFG_RUNTIME_WR_EN
  ,
  input  logic                   wr_req_i,
  input  logic [ADC_FRAME_W-1:0] wr_data_i,
  output logic                   wr_ack_o
`endif
);

  localparam int IDX_W = $clog2(NUM_REGS + 1);
  localparam int TO_W  = $clog2(START_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_END     = IDX_W'(NUM_REGS);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(START_TIMEOUT - 1);
  localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      set_cnt_q, set_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             fetch_ph_q, fetch_ph_d;   // 0: read issued, 1: word ready
  logic             rt_q, rt_d;               // current frame is a runtime write
  frame_t           spi_data_q, spi_data_d;
  logic             spi_init_q, spi_init_d;
  logic             cfg_done_q, cfg_done_d;
  logic             cfg_err_q, cfg_err_d;
  logic             settle_done;
  logic             rom_rd;
  logic             go_acc;
  frame_t           rom_data;

`ifdef ADC_CFG_RUNTIME_WR_EN
  logic             wr_ack_q, wr_ack_d;
  assign wr_ack_o = wr_ack_q;
`endif

  adc_cfg_rom #(.IDX_W(IDX_W)) u_rom (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .rd_en_i (rom_rd),
    .idx_i   (idx_q),
    .data_o  (rom_data)
  );

  // The SPI master may still be finishing a frame (it has no reset), so a
  // go is only taken once it is idle.
  assign go_acc      = cfg_go_i & ~spi_busy_i;
  assign spi_start_o = (state_q == ST_REQ);
  assign seq_busy_o  = (state_q != ST_IDLE) && (state_q != ST_READY);
  assign spi_data_o  = spi_data_q;
  assign spi_init_o  = spi_init_q;
  assign cfg_done_o  = cfg_done_q;
  assign cfg_err_o   = cfg_err_q;

  // Next-state and datapath updates for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    set_cnt_d   = set_cnt_q;
    to_cnt_d    = to_cnt_q;
    fetch_ph_d  = fetch_ph_q;
    rt_d        = rt_q;
    spi_data_d  = spi_data_q;
    spi_init_d  = spi_init_q;
    cfg_done_d  = cfg_done_q;
    cfg_err_d   = cfg_err_q;
    settle_done = 1'b0;
    rom_rd      = 1'b0;
`ifdef ADC_CFG_RUNTIME_WR_EN
    wr_ack_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE, ST_READY: begin
        if (go_acc) begin
          cfg_done_d = 1'b0;
          cfg_err_d  = 1'b0;
          idx_d      = '0;
          spi_init_d = 1'b1;
          spi_data_d = '0;
          rt_d       = 1'b0;
          to_cnt_d   = '0;
          state_d    = ST_REQ;
        end
`ifdef ADC_CFG_RUNTIME_WR_EN
        // A go in the same cycle wins, even if it is refused for busy.
        else if (state_q == ST_READY && wr_req_i && !cfg_go_i) begin
          spi_data_d = wr_data_i;
          spi_init_d = 1'b0;
          rt_d       = 1'b1;
          wr_ack_d   = 1'b1;
          to_cnt_d   = '0;
          state_d    = ST_REQ;
        end
`endif
      end
      ST_FETCH: begin
        if (!fetch_ph_q) begin
          rom_rd     = 1'b1;
          fetch_ph_d = 1'b1;
        end else begin
          spi_data_d = rom_data;
          idx_d      = idx_q + IDX_W'(1);
          fetch_ph_d = 1'b0;
          to_cnt_d   = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (spi_busy_i) begin
          state_d = ST_XFER;
        end else if (to_cnt_q == TO_LAST) begin
          cfg_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_XFER: begin
        if (!spi_busy_i) begin
          spi_init_d = 1'b0;
          if (SETTLE_CYCLES == 0) begin
            settle_done = 1'b1;
          end else begin
            set_cnt_d = '0;
            state_d   = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (set_cnt_q == SETTLE_LAST) settle_done = 1'b1;
        else                          set_cnt_d   = set_cnt_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (settle_done) begin
      if (rt_q) begin
        rt_d    = 1'b0;
        state_d = ST_READY;
      end else if (idx_q < IDX_END) begin
        fetch_ph_d = 1'b0;
        state_d    = ST_FETCH;
      end else begin
        cfg_done_d = 1'b1;
        state_d    = ST_READY;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      set_cnt_q  <= '0;
      to_cnt_q   <= '0;
      fetch_ph_q <= 1'b0;
      rt_q       <= 1'b0;
      spi_data_q <= '0;
      spi_init_q <= 1'b0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      set_cnt_q  <= set_cnt_d;
      to_cnt_q   <= to_cnt_d;
      fetch_ph_q <= fetch_ph_d;
      rt_q       <= rt_d;
      spi_data_q <= spi_data_d;
      spi_init_q <= spi_init_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

`ifdef ADC_CFG_RUNTIME_WR_EN
  // Acknowledge pulse for a captured runtime write.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) wr_ack_q <= 1'b0;
    else          wr_ack_q <= wr_ack_d;
  end
`endif

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Self-checking bench for adc_cfg_sequencer with a behavioural SPI master.
// Runtime-write checks are included when ADC_CFG_RUNTIME_WR_EN is defined.
module tb_adc_cfg_sequencer;
  import adc_cfg_pkg::*;

  localparam int NREG   = 3;
  localparam int SETTLE = 4;
  localparam int TMO    = 32;
  localparam int FLEN   = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_go = 1'b0;
  logic        spi_busy = 1'b0;
  logic        cfg_done, cfg_err, seq_busy, spi_start, spi_init;
  logic [39:0] spi_data;
`ifdef ADC_CFG_RUNTIME_WR_EN
  logic        wr_req = 1'b0;
  logic [39:0] wr_data = '0;
  logic        wr_ack;
`endif

  always #5 clk = ~clk;

  adc_cfg_sequencer #(
    .NUM_REGS      (NREG),
    .SETTLE_CYCLES (SETTLE),
    .START_TIMEOUT (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cfg_go_i    (cfg_go),
    .cfg_done_o  (cfg_done),
    .cfg_err_o   (cfg_err),
    .seq_busy_o  (seq_busy),
    .spi_start_o (spi_start),
    .spi_init_o  (spi_init),
    .spi_busy_i  (spi_busy),
    .spi_data_o  (spi_data)
`ifdef ADC_CFG_RUNTIME_WR_EN
    ,
    .wr_req_i    (wr_req),
    .wr_data_i   (wr_data),
    .wr_ack_o    (wr_ack)
`endif
  );

  typedef struct packed {
    logic        init;
    logic [39:0] data;
  } frm_t;

  int   nvec = 0, nerr = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   hold_viol = 0;
  int   ack_cnt = 0;
  int   m_cnt = 0;
  int   m_lo = FLEN, m_hi = FLEN;
  bit   m_en = 1'b1;
  bit   hold_chk = 1'b1;
  frm_t cur;
  frm_t frames[$];

  always @(posedge clk) cyc <= cyc + 1;

  // SPI master model: samples start on the falling edge, records each frame
  // word at start, and watches that the word stays frozen while busy.
  always @(negedge clk) begin
    if (spi_busy) begin
      if (hold_chk && (spi_data !== cur.data || spi_init !== cur.init)) hold_viol++;
      m_cnt--;
      if (m_cnt <= 0) begin
        spi_busy = 1'b0;
        fall_cyc = cyc;
      end
    end else if (m_en && spi_start === 1'b1) begin
      cur = '{init: spi_init, data: spi_data};
      frames.push_back(cur);
      m_cnt = int'($urandom_range(m_hi, m_lo));
      spi_busy = 1'b1;
    end
  end

`ifdef ADC_CFG_RUNTIME_WR_EN
  always @(negedge clk) if (wr_ack === 1'b1) ack_cnt++;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle go pulse; returns #1 after the accepting edge.
  task automatic go_pulse();
    @(negedge clk);
    cfg_go = 1'b1;
    @(posedge clk);
    #1;
    cfg_go = 1'b0;
  endtask

  // Expected frame list: init frame then the table in order.
  function automatic frm_t exp_frame(input int i);
    frm_t e;
    if (i == 0) e = '{init: 1'b1, data: 40'h0};
    else        e = '{init: 1'b0, data: DEF_REG_TABLE[i-1]};
    return e;
  endfunction

  task automatic check_frames(input string tag);
    chk({tag, "_nframes"}, 64'(frames.size()), 64'(NREG + 1));
    for (int i = 0; i < frames.size() && i <= NREG; i++)
      chk($sformatf("%s_frame%0d", tag, i), 64'(frames[i]), 64'(exp_frame(i)));
  endtask

  task automatic run_seq(input string tag);
    bit ok;
    frames.delete();
    hold_viol = 0;
    go_pulse();
    chk({tag, "_start_lat"}, 64'(spi_start), 64'd1);
    chk({tag, "_init_hi"},   64'(spi_init),  64'd1);
    chk({tag, "_done_clr"},  64'(cfg_done),  64'd0);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (cfg_done === 1'b1) begin ok = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    if (ok) chk({tag, "_done_lat"}, 64'(cyc - fall_cyc), 64'(SETTLE + 1));
    chk({tag, "_seq_idle"}, 64'(seq_busy), 64'd0);
    chk({tag, "_no_err"},   64'(cfg_err),  64'd0);
    chk({tag, "_hold"},     64'(hold_viol), 64'd0);
    check_frames(tag);
  endtask

  initial begin
    bit ok;
    int n;
    logic [39:0] wd;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 64'({spi_start, spi_init, cfg_done, cfg_err, seq_busy}), 64'd0);
    chk("rst_data", 64'(spi_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat ($urandom_range(5, 1)) @(negedge clk);

    // Full sequence with 40-clock frames, then again with random frame lengths.
    run_seq("seq40");
    m_lo = 3; m_hi = 60;
    run_seq("seqrand");
    m_lo = FLEN; m_hi = FLEN;

    // Start timeout with the SPI master silent.
    m_en = 1'b0;
    go_pulse();
    n = 0;
    while (spi_start === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("tmo_start_len", 64'(n), 64'(TMO));
    chk("tmo_err", 64'(cfg_err), 64'd1);
    chk("tmo_done", 64'(cfg_done), 64'd0);
    chk("tmo_idle", 64'(seq_busy), 64'd0);
    m_en = 1'b1;

`ifdef ADC_CFG_RUNTIME_WR_EN
    run_seq("pre_wr");
    for (int k = 0; k < 2; k++) begin
      wd = (k == 0) ? 40'h00_1234_56AB : {$urandom(), 8'($urandom())};
      frames.delete();
      ack_cnt = 0;
      hold_viol = 0;
      @(negedge clk);
      wr_req = 1'b1;
      wr_data = wd;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (wr_ack === 1'b1) begin ok = 1'b1; break; end
      end
      wr_req = 1'b0;
      chk($sformatf("wr%0d_ack_seen", k), 64'(ok), 64'd1);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (seq_busy === 1'b0) begin ok = 1'b1; break; end
      end
      chk($sformatf("wr%0d_finish", k), 64'(ok), 64'd1);
      chk($sformatf("wr%0d_ack_cnt", k), 64'(ack_cnt), 64'd1);
      chk($sformatf("wr%0d_nframes", k), 64'(frames.size()), 64'd1);
      if (frames.size() > 0)
        chk($sformatf("wr%0d_frame", k), 64'(frames[0]), 64'({1'b0, wd}));
      chk($sformatf("wr%0d_done_kept", k), 64'(cfg_done), 64'd1);
      chk($sformatf("wr%0d_hold", k), 64'(hold_viol), 64'd0);
    end

    // go and wr_req together in READY: go wins.
    ack_cnt = 0;
    frames.delete();
    hold_viol = 0;
    @(negedge clk);
    cfg_go = 1'b1;
    wr_req = 1'b1;
    wr_data = {$urandom(), 8'($urandom())};
    @(posedge clk);
    #1;
    cfg_go = 1'b0;
    wr_req = 1'b0;
    chk("sim_restart_init", 64'(spi_init), 64'd1);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (cfg_done === 1'b1) begin ok = 1'b1; break; end
    end
    chk("sim_done_seen", 64'(ok), 64'd1);
    chk("sim_no_ack", 64'(ack_cnt), 64'd0);
    check_frames("sim");
`endif

    // Reset in the middle of frame 2 with the master stretching busy.
    frames.delete();
    go_pulse();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (frames.size() == 2) begin ok = 1'b1; break; end
    end
    chk("rmf_frame2_seen", 64'(ok), 64'd1);
    repeat ($urandom_range(10, 1)) @(negedge clk);
    hold_chk = 1'b0;
    @(posedge clk);
    #1;
    m_cnt = 20;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rmf_rst_start", 64'(spi_start), 64'd0);
    chk("rmf_rst_state", 64'({seq_busy, cfg_done, spi_init}), 64'd0);
    rst_n = 1'b1;
    go_pulse();
    chk("rmf_go_ignored", 64'({seq_busy, spi_start}), 64'd0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (spi_busy === 1'b0) begin ok = 1'b1; break; end
    end
    chk("rmf_busy_released", 64'(ok), 64'd1);
    chk("rmf_still_idle", 64'(seq_busy), 64'd0);
    hold_chk = 1'b1;
    run_seq("rmf_restart");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
